uart_rx_fifo_ctrl: RTL and testbench

- Parametrised successor UART receiver for the serial bridge.
- Adds runtime baud divisor, 16x oversampling with 3-sample majority vote, configurable parity and 1/2 stop bits.
- Adds per-frame error flags and an output FIFO with valid/ready handshake, so the bridge can drain frames without losing back-to-back bytes.

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_sync_fifo.sv | 61 ++++++
 rtl/uart_rx_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver with output FIFO.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    PUSH
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Small first-word-fall-through FIFO with occupancy count; the head entry is
// always visible on o_rdata while o_valid is high.
module uart_rx_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_valid,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPop;
  logic             w_doPush;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_doPop  = i_pop && (r_count != '0);
  assign w_doPush = i_push && (!o_full || w_doPop);

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_wdata;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// Oversampling UART receiver with majority vote, parity/stop checking and an
// output FIFO. Define UART_RX_BREAK_DETECT_EN to add the break_det output.
module uart_rx_fifo_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_LEN   = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  parity_mode,
  input  logic                        two_stop,
  input  logic                        rx_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_LEN-1:0]         out_data,
  output logic                        out_parity_err,
  output logic                        out_frame_err,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef UART_RX_BREAK_DETECT_EN
  ,
  output logic                        break_det
`endif
);

  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_LEN);
  localparam int FW    = DATA_LEN + 2;
  localparam logic [SUB_W-1:0] SMP_A    = SUB_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SUB_W-1:0] SMP_B    = SUB_W'(OVERSAMPLE / 2);
  localparam logic [SUB_W-1:0] SMP_C    = SUB_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_LEN - 1);

  rx_state_t            r_state;
  rx_state_t            w_stateNext;
  logic                 r_rxMeta;
  logic                 r_rxS;
  logic [DIV_W-1:0]     r_baudDiv;
  logic [DIV_W-1:0]     r_tickCnt;
  logic [1:0]           r_parMode;
  logic                 r_twoStop;
  logic [SUB_W-1:0]     r_subCnt;
  logic [BIT_W-1:0]     r_bitIdx;
  logic                 r_stopIdx;
  logic                 r_s0;
  logic                 r_s1;
  logic                 r_armed;
  logic                 r_parErr;
  logic                 r_frameErr;
  logic                 r_overrun;
  logic [DATA_LEN-1:0]  r_shift;

  logic                 w_tick;
  logic                 w_smpA;
  logic                 w_smpB;
  logic                 w_smpLast;
  logic                 w_bitEnd;
  logic                 w_maj;
  logic                 w_parEn;
  logic                 w_lastStop;
  logic                 w_startFrame;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic [FW-1:0]        w_fifoRd;

  assign w_tick       = (r_state != IDLE) && (r_tickCnt == r_baudDiv);
  assign w_smpA       = w_tick && (r_subCnt == SMP_A);
  assign w_smpB       = w_tick && (r_subCnt == SMP_B);
  assign w_smpLast    = w_tick && (r_subCnt == SMP_C);
  assign w_bitEnd     = w_tick && (r_subCnt == SUB_LAST);
  assign w_maj        = maj3(r_s0, r_s1, r_rxS);
  assign w_parEn      = (r_parMode == PAR_EVEN) || (r_parMode == PAR_ODD);
  assign w_lastStop   = r_stopIdx || !r_twoStop;
  assign w_startFrame = (r_state == IDLE) && r_armed && !r_rxS;
  assign w_pop        = out_valid && out_ready;
  assign overrun      = r_overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rxMeta <= 1'b1;
      r_rxS    <= 1'b1;
    end else begin
      r_rxMeta <= rx_data;
      r_rxS    <= r_rxMeta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // The frame is handed over mid-way through the last stop bit so that a
  // start edge immediately following it is still caught from IDLE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:   if (w_startFrame) w_stateNext = START;
      START: begin
        if (w_smpLast && w_maj)  w_stateNext = IDLE;
        else if (w_bitEnd)       w_stateNext = DATA;
      end
      DATA:   if (w_bitEnd && (r_bitIdx == LAST_BIT)) w_stateNext = w_parEn ? PARITY : STOP;
      PARITY: if (w_bitEnd) w_stateNext = STOP;
      STOP:   if (w_smpLast && w_lastStop) w_stateNext = PUSH;
      PUSH:   w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baudDiv  <= '0;
      r_tickCnt  <= '0;
      r_parMode  <= 2'd0;
      r_twoStop  <= 1'b0;
      r_subCnt   <= '0;
      r_bitIdx   <= '0;
      r_stopIdx  <= 1'b0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_armed    <= 1'b0;
      r_parErr   <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
      r_shift    <= '0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;

      if ((r_state == IDLE) || w_tick) r_tickCnt <= '0;
      else                             r_tickCnt <= r_tickCnt + 1'b1;

      if (r_state == IDLE)  r_subCnt <= '0;
      else if (w_bitEnd)    r_subCnt <= '0;
      else if (w_tick)      r_subCnt <= r_subCnt + 1'b1;

      if (w_smpA) r_s0 <= r_rxS;
      if (w_smpB) r_s1 <= r_rxS;

      if (w_startFrame) begin
        r_baudDiv  <= baud_div;
        r_parMode  <= parity_mode;
        r_twoStop  <= two_stop;
        r_bitIdx   <= '0;
        r_stopIdx  <= 1'b0;
        r_parErr   <= 1'b0;
        r_frameErr <= 1'b0;
      end

      // A frame ending in a framing error leaves the receiver disarmed until
      // the line returns high, so a stuck-low line cannot retrigger.
      case (r_state)
        IDLE: if (r_rxS) r_armed <= 1'b1;
        DATA: begin
          if (w_smpLast) r_shift  <= {w_maj, r_shift[DATA_LEN-1:1]};
          if (w_bitEnd)  r_bitIdx <= r_bitIdx + 1'b1;
        end
        PARITY: begin
          if (w_smpLast) begin
            if (r_parMode == PAR_ODD) r_parErr <= ~(^r_shift ^ w_maj);
            else                      r_parErr <= ^r_shift ^ w_maj;
          end
        end
        STOP: begin
          if (w_smpLast && !w_maj) r_frameErr <= 1'b1;
          if (w_bitEnd)            r_stopIdx  <= 1'b1;
        end
        PUSH: r_armed <= !r_frameErr;
        default: ;
      endcase
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic r_parBit;
  logic r_stop1Low;
  logic w_isBreak;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_parBit   <= 1'b0;
      r_stop1Low <= 1'b0;
    end else begin
      if (w_startFrame) begin
        r_parBit   <= 1'b0;
        r_stop1Low <= 1'b0;
      end
      if ((r_state == PARITY) && w_smpLast)             r_parBit   <= w_maj;
      if ((r_state == STOP) && w_smpLast && !r_stopIdx) r_stop1Low <= !w_maj;
    end
  end

  // A break is an all-zero frame whose first stop bit is also low; it is
  // reported on break_det instead of entering the FIFO.
  assign w_isBreak = (r_state == PUSH) && (r_shift == '0) && r_stop1Low
                     && !(w_parEn && r_parBit);
  assign break_det = w_isBreak;
  assign w_push    = (r_state == PUSH) && !w_isBreak;
`else
  assign w_push    = (r_state == PUSH);
`endif

  uart_rx_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata ({r_frameErr, r_parErr, r_shift}),
    .i_pop   (w_pop),
    .o_rdata (w_fifoRd),
    .o_valid (out_valid),
    .o_full  (w_full),
    .o_count (fifo_count)
  );

  assign out_data       = w_fifoRd[DATA_LEN-1:0];
  assign out_parity_err = w_fifoRd[DATA_LEN];
  assign out_frame_err  = w_fifoRd[DATA_LEN+1];

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl: serial frames are driven bit by bit
// and the FIFO head is compared with hand-computed frames and flags.
module tb_uart_rx_fifo_ctrl;

  localparam int OVERSAMPLE = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        rx_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_parity_err;
  logic        out_frame_err;
  logic        overrun;
  logic [2:0]  fifo_count;
`ifdef UART_RX_BREAK_DETECT_EN
  logic        break_det;
`endif

  int   nChecks = 0;
  int   nPass = 0;
  int   cyc = 0;
  int   lastRise = -1;
  int   ovCnt = 0;
  int   brkCnt = 0;
  logic prevValid = 1'b0;

  uart_rx_fifo_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .baud_div       (baud_div),
    .parity_mode    (parity_mode),
    .two_stop       (two_stop),
    .rx_data        (rx_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_parity_err (out_parity_err),
    .out_frame_err  (out_frame_err),
    .overrun        (overrun),
    .fifo_count     (fifo_count)
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    .break_det      (break_det)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Event monitors sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && prevValid !== 1'b1) lastRise = cyc;
    prevValid = out_valid;
    if (overrun === 1'b1) ovCnt++;
`ifdef UART_RX_BREAK_DETECT_EN
    if (break_det === 1'b1) brkCnt++;
`endif
  end

  task automatic holdBit(input logic v);
    rx_data = v;
    repeat (OVERSAMPLE * (int'(baud_div) + 1)) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] d, input bit withPar, input logic pBit,
                           input logic s1, input bit useS2, input logic s2);
    holdBit(1'b0);
    for (int i = 0; i < 8; i++) holdBit(d[i]);
    if (withPar) holdBit(pBit);
    holdBit(s1);
    if (useS2) holdBit(s2);
    rx_data = 1'b1;
  endtask

  task automatic popOne();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_data = 1'b1;
    baud_div = 16'd0;
    parity_mode = 2'd0;
    two_stop = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++;
    if ({out_valid, out_parity_err, out_frame_err, overrun} !== 4'b0000)
      $display("[TB] FAIL reset_flags: got %b want 0000", {out_valid, out_parity_err, out_frame_err, overrun});
    else nPass++;
    nChecks++;
    if (out_data !== 8'h00 || fifo_count !== 3'd0)
      $display("[TB] FAIL reset_data_count: got %h/%0d want 00/0", out_data, fifo_count);
    else nPass++;
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_8n1();
    int startCyc;
    startCyc = cyc;
    sendFrame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    // 2 sync + 1 to START + 9 bit periods + 9 ticks into stop bit + PUSH + FIFO write
    nChecks++;
    if (lastRise - startCyc !== 158)
      $display("[TB] FAIL basic_latency: got %0d want 158", lastRise - startCyc);
    else nPass++;
    nChecks++;
    if ({out_valid, out_data, out_parity_err, out_frame_err} !== {1'b1, 8'hA5, 2'b00})
      $display("[TB] FAIL basic_frame: got v=%b d=%h pe=%b fe=%b want v=1 d=a5 pe=0 fe=0",
               out_valid, out_data, out_parity_err, out_frame_err);
    else nPass++;
    popOne();
    nChecks++;
    if (fifo_count !== 3'd0)
      $display("[TB] FAIL basic_pop_count: got %0d want 0", fifo_count);
    else nPass++;
  endtask

  task automatic test_back_to_back();
    sendFrame(8'h5C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    sendFrame(8'h3A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    nChecks++;
    if (fifo_count !== 3'd2 || out_data !== 8'h5C)
      $display("[TB] FAIL b2b_first: got cnt=%0d d=%h want cnt=2 d=5c", fifo_count, out_data);
    else nPass++;
    popOne();
    nChecks++;
    if (out_data !== 8'h3A || out_frame_err !== 1'b0)
      $display("[TB] FAIL b2b_second: got d=%h fe=%b want d=3a fe=0", out_data, out_frame_err);
    else nPass++;
    popOne();
  endtask

  task automatic test_parity();
    parity_mode = 2'd1;
    sendFrame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    nChecks++;
    if ({out_valid, out_data, out_parity_err, out_frame_err} !== {1'b1, 8'h3C, 2'b10})
      $display("[TB] FAIL parity_even: got v=%b d=%h pe=%b fe=%b want v=1 d=3c pe=1 fe=0",
               out_valid, out_data, out_parity_err, out_frame_err);
    else nPass++;
    popOne();
    parity_mode = 2'd2;
    sendFrame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    nChecks++;
    if ({out_valid, out_data, out_parity_err} !== {1'b1, 8'h3C, 1'b0})
      $display("[TB] FAIL parity_odd: got v=%b d=%h pe=%b want v=1 d=3c pe=0",
               out_valid, out_data, out_parity_err);
    else nPass++;
    popOne();
    parity_mode = 2'd0;
  endtask

  task automatic test_two_stop();
    two_stop = 1'b1;
    sendFrame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    nChecks++;
    if ({out_valid, out_data, out_frame_err} !== {1'b1, 8'h81, 1'b1})
      $display("[TB] FAIL two_stop_err: got v=%b d=%h fe=%b want v=1 d=81 fe=1",
               out_valid, out_data, out_frame_err);
    else nPass++;
    popOne();
    repeat (32) @(negedge clk);
    sendFrame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    nChecks++;
    if ({out_valid, out_data, out_parity_err, out_frame_err, fifo_count} !== {1'b1, 8'h11, 2'b00, 3'd1})
      $display("[TB] FAIL two_stop_clean: got v=%b d=%h pe=%b fe=%b cnt=%0d want v=1 d=11 pe=0 fe=0 cnt=1",
               out_valid, out_data, out_parity_err, out_frame_err, fifo_count);
    else nPass++;
    popOne();
    two_stop = 1'b0;
  endtask

  task automatic test_glitch();
    rx_data = 1'b0;
    @(negedge clk);
    rx_data = 1'b1;
    repeat (40) @(negedge clk);
    nChecks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0)
      $display("[TB] FAIL glitch_no_frame: got v=%b cnt=%0d want v=0 cnt=0", out_valid, fifo_count);
    else nPass++;
    sendFrame(8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    nChecks++;
    if ({out_valid, out_data, fifo_count} !== {1'b1, 8'h42, 3'd1})
      $display("[TB] FAIL glitch_recover: got v=%b d=%h cnt=%0d want v=1 d=42 cnt=1",
               out_valid, out_data, fifo_count);
    else nPass++;
    popOne();
  endtask

  task automatic test_overrun();
    int ov0;
    logic [7:0] expD [4] = '{8'h02, 8'h03, 8'h04, 8'h06};
    ov0 = ovCnt;
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) sendFrame(8'(v), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    nChecks++;
    if (fifo_count !== 3'd4 || out_data !== 8'h01)
      $display("[TB] FAIL overrun_full: got cnt=%0d d=%h want cnt=4 d=01", fifo_count, out_data);
    else nPass++;
    nChecks++;
    if (ovCnt - ov0 !== 1)
      $display("[TB] FAIL overrun_pulses: got %0d want 1", ovCnt - ov0);
    else nPass++;
    // The pop is timed onto the PUSH cycle of frame 0x06, 157 edges after its start bit.
    fork
      sendFrame(8'h06, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        repeat (157) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    join
    nChecks++;
    if (fifo_count !== 3'd4 || ovCnt - ov0 !== 1)
      $display("[TB] FAIL overrun_push_pop: got cnt=%0d pulses=%0d want cnt=4 pulses=1",
               fifo_count, ovCnt - ov0);
    else nPass++;
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if (out_valid !== 1'b1 || out_data !== expD[i])
        $display("[TB] FAIL overrun_drain%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, expD[i]);
      else nPass++;
      popOne();
    end
    nChecks++;
    if (fifo_count !== 3'd0)
      $display("[TB] FAIL overrun_empty: got %0d want 0", fifo_count);
    else nPass++;
  endtask

  task automatic test_reset_mid_frame();
    baud_div = 16'd3;
    sendFrame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    rx_data = 1'b0;
    repeat (64 * 3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    nChecks++;
    if ({out_valid, out_data, out_parity_err, out_frame_err, overrun, fifo_count} !== 15'd0)
      $display("[TB] FAIL midreset_outputs: got v=%b d=%h pe=%b fe=%b ov=%b cnt=%0d want all 0",
               out_valid, out_data, out_parity_err, out_frame_err, overrun, fifo_count);
    else nPass++;
    rx_data = 1'b1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    sendFrame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    nChecks++;
    if ({out_valid, out_data, out_parity_err, out_frame_err, fifo_count} !== {1'b1, 8'h5A, 2'b00, 3'd1})
      $display("[TB] FAIL midreset_next: got v=%b d=%h pe=%b fe=%b cnt=%0d want v=1 d=5a pe=0 fe=0 cnt=1",
               out_valid, out_data, out_parity_err, out_frame_err, fifo_count);
    else nPass++;
    popOne();
    baud_div = 16'd0;
  endtask

  task automatic test_break();
    int brk0;
    brk0 = brkCnt;
    rx_data = 1'b0;
    repeat (12 * OVERSAMPLE) @(negedge clk);
    rx_data = 1'b1;
    repeat (32) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
    nChecks++;
    if (brkCnt - brk0 !== 1)
      $display("[TB] FAIL break_pulses: got %0d want 1", brkCnt - brk0);
    else nPass++;
    nChecks++;
    if (fifo_count !== 3'd0)
      $display("[TB] FAIL break_no_push: got cnt=%0d want 0", fifo_count);
    else nPass++;
`else
    nChecks++;
    if (brkCnt - brk0 !== 0 || fifo_count !== 3'd1)
      $display("[TB] FAIL break_count: got cnt=%0d want 1", fifo_count);
    else nPass++;
    nChecks++;
    if ({out_data, out_parity_err, out_frame_err} !== {8'h00, 2'b01})
      $display("[TB] FAIL break_frame: got d=%h pe=%b fe=%b want d=00 pe=0 fe=1",
               out_data, out_parity_err, out_frame_err);
    else nPass++;
    popOne();
`endif
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    test_break();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
